// File: rtl/lcd_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_tx_if
// Purpose  : Bundles the controller-side byte handshake and the LCD panel SPI
//            pins of the LCD SPI transmitter.
// Signals  : data_in[7:0], data_dcx, start   - request from the controller
//            done, busy                      - status back to the controller
//            spi_sck, spi_mosi, spi_cs_n,
//            spi_dcx                         - pins toward the panel
// Modports : master - controller/testbench side (drives the request)
//            slave  - transmitter side (drives status and SPI pins)
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_spi_tx_if;
    logic [7:0] data_in;
    logic       data_dcx;
    logic       start;
    logic       done;
    logic       busy;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_dcx;

    modport master (
        output data_in, data_dcx, start,
        input  done, busy, spi_sck, spi_mosi, spi_cs_n, spi_dcx
    );

    modport slave (
        input  data_in, data_dcx, start,
        output done, busy, spi_sck, spi_mosi, spi_cs_n, spi_dcx
    );
endinterface
`default_nettype wire

// File: rtl/lcd_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_tx
// Purpose  : Byte-serial SPI mode-0 transmitter for the LCD panel. Sends one
//            byte MSB-first per accepted start, pulses done, and keeps chip
//            select low for CS_IDLE cycles afterwards so streamed bytes share
//            one CS frame.
// Params   : CLK_DIV - SCK half-period in clk cycles (>= 1)
//            CS_IDLE - cycles CS lingers low after done (>= 1)
// Ports    : clk  - system clock
//            rst  - synchronous reset, active low
//            bus  - lcd_spi_tx_if.slave (handshake + SPI pins)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_tx #(
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    lcd_spi_tx_if.slave  bus
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int LIN_W = $clog2(CS_IDLE) + 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [LIN_W-1:0] c_lin_last = LIN_W'(CS_IDLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LINGER = 2'd2
    } state_t;

    state_t           r_state;
    logic [6:0]       r_shift;   // remaining bits; MSB is already on mosi
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit;
    logic [LIN_W-1:0] r_lin;
    logic             r_sck;
    logic             r_mosi;
    logic             r_cs_n;
    logic             r_dcx;
    logic             r_done;
    logic             r_busy;

    logic             w_accept;

    // A request is only taken while no byte is in flight.
    assign w_accept = bus.start && (r_state != ST_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_lin   <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_dcx   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LINGER: begin
                    // Accept has priority over the linger timeout so a byte
                    // arriving on the timeout edge keeps CS low.
                    if (w_accept) begin
                        r_shift <= bus.data_in[6:0];
                        r_mosi  <= bus.data_in[7];
                        r_dcx   <= bus.data_dcx;
                        r_cs_n  <= 1'b0;
                        r_sck   <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_lin   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else if (r_state == ST_LINGER) begin
                        if (r_lin == c_lin_last) begin
                            r_cs_n  <= 1'b1;
                            r_lin   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_lin <= r_lin + LIN_W'(1);
                        end
                    end
                end

                ST_SHIFT: begin
                    if (r_div == c_div_last) begin
                        r_div <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit == 3'd7) begin
                                // Last falling edge: mosi keeps bit 0.
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_lin   <= '0;
                                r_state <= ST_LINGER;
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_mosi  <= r_shift[6];
                                r_shift <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
    assign bus.spi_sck  = r_sck;
    assign bus.spi_mosi = r_mosi;
    assign bus.spi_cs_n = r_cs_n;
    assign bus.spi_dcx  = r_dcx;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_spi_tx
// Purpose  : Directed self-checking bench for lcd_spi_tx. DUT0 runs with
//            CLK_DIV=2/CS_IDLE=16, DUT1 with CLK_DIV=1/CS_IDLE=4. Monitors
//            capture MOSI on rising SCK and time-stamp done and CS release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_spi_tx_if ifc0 ();
    lcd_spi_tx_if ifc1 ();

    lcd_spi_tx #(.CLK_DIV(2), .CS_IDLE(16)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    lcd_spi_tx #(.CLK_DIV(1), .CS_IDLE(4))  dut1 (.clk(clk), .rst(rst), .bus(ifc1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitors (sample on the falling clk edge) ------------
    logic [15:0] cap0, cap1;
    int rise0, rise1, done_n0, done_n1, done_cyc0, done_cyc1;
    int cs_rise0, cs_rise1, cs_cyc0, cs_cyc1, tog1;
    logic prev_sck0, prev_cs0, prev_sck1, prev_cs1;

    always @(negedge clk) begin
        if (ifc0.spi_sck === 1'b1 && prev_sck0 === 1'b0) begin
            cap0  <= {cap0[14:0], ifc0.spi_mosi};
            rise0 <= rise0 + 1;
        end
        if (ifc0.done === 1'b1) begin
            done_n0   <= done_n0 + 1;
            done_cyc0 <= cyc;
        end
        if (ifc0.spi_cs_n === 1'b1 && prev_cs0 === 1'b0) begin
            cs_rise0 <= cs_rise0 + 1;
            cs_cyc0  <= cyc;
        end
        prev_sck0 <= ifc0.spi_sck;
        prev_cs0  <= ifc0.spi_cs_n;
    end

    always @(negedge clk) begin
        if (ifc1.spi_sck === 1'b1 && prev_sck1 === 1'b0) begin
            cap1  <= {cap1[14:0], ifc1.spi_mosi};
            rise1 <= rise1 + 1;
        end
        if (ifc1.spi_sck !== prev_sck1)
            tog1 <= tog1 + 1;
        if (ifc1.done === 1'b1) begin
            done_n1   <= done_n1 + 1;
            done_cyc1 <= cyc;
        end
        if (ifc1.spi_cs_n === 1'b1 && prev_cs1 === 1'b0) begin
            cs_rise1 <= cs_rise1 + 1;
            cs_cyc1  <= cyc;
        end
        prev_sck1 <= ifc1.spi_sck;
        prev_cs1  <= ifc1.spi_cs_n;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear0();
        cap0 = '0; rise0 = 0; done_n0 = 0; cs_rise0 = 0; done_cyc0 = 0; cs_cyc0 = 0;
    endtask

    task automatic clear1();
        cap1 = '0; rise1 = 0; done_n1 = 0; cs_rise1 = 0; done_cyc1 = 0; cs_cyc1 = 0; tog1 = 0;
    endtask

    // Raise start now (at a falling edge); returns the accepting edge index.
    task automatic pulse(input bit which, input logic [7:0] d, input logic dc, output int e0);
        if (which) begin
            ifc1.data_in = d; ifc1.data_dcx = dc; ifc1.start = 1'b1;
        end else begin
            ifc0.data_in = d; ifc0.data_dcx = dc; ifc0.start = 1'b1;
        end
        @(negedge clk);
        ifc0.start = 1'b0;
        ifc1.start = 1'b0;
        e0 = cyc;
    endtask

    task automatic send(input bit which, input logic [7:0] d, input logic dc, output int e0);
        @(negedge clk);
        pulse(which, d, dc, e0);
    endtask

    task automatic wait_done(input bit which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? ifc1.done : ifc0.done) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check("done_seen", (at >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- watchdog ---------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ---------------------------------------------
    initial begin
        int e0, e1, d, d1, d2, tmp;
        ifc0.data_in = '0; ifc0.data_dcx = 1'b0; ifc0.start = 1'b0;
        ifc1.data_in = '0; ifc1.data_dcx = 1'b0; ifc1.start = 1'b0;
        rst = 1'b0;
        wait_cycles(3);

        // Reset state
        check("rst_cs_n", ifc0.spi_cs_n, 1);
        check("rst_sck",  ifc0.spi_sck,  0);
        check("rst_mosi", ifc0.spi_mosi, 0);
        check("rst_dcx",  ifc0.spi_dcx,  0);
        check("rst_done", ifc0.done,     0);
        check("rst_busy", ifc0.busy,     0);
        rst = 1'b1;
        wait_cycles(2);
        clear0();
        clear1();

        // T1: single byte 0xA5, data
        send(0, 8'hA5, 1'b1, e0);
        check("t1_busy",  ifc0.busy,     1);
        check("t1_cs_lo", ifc0.spi_cs_n, 0);
        check("t1_mosi0", ifc0.spi_mosi, 1);
        wait_done(0, 100, d);
        check("t1_done_lat", d - e0, 32);
        check("t1_rises",    rise0,  8);
        check("t1_byte",     cap0[7:0], 8'hA5);
        check("t1_dcx",      ifc0.spi_dcx, 1);
        check("t1_busy_off", ifc0.busy, 0);
        wait_cycles(20);
        check("t1_cs_rises", cs_rise0, 1);
        check("t1_cs_time",  cs_cyc0 - e0, 48);
        check("t1_dones",    done_n0, 1);
        check("t1_dcx_hold", ifc0.spi_dcx, 1);

        // T2: back-to-back 0x2C (cmd) then 0xFF (data)
        clear0();
        send(0, 8'h2C, 1'b0, e0);
        check("t2_dcx0", ifc0.spi_dcx, 0);
        wait_done(0, 100, d1);
        pulse(0, 8'hFF, 1'b1, e1);
        check("t2_dcx1",  ifc0.spi_dcx,  1);
        check("t2_cs_lo", ifc0.spi_cs_n, 0);
        wait_done(0, 100, d2);
        check("t2_gap",      d2 - d1, 33);
        check("t2_rises",    rise0, 16);
        check("t2_bytes",    cap0, 16'h2CFF);
        check("t2_no_cs_up", cs_rise0, 0);
        wait_cycles(20);
        check("t2_dones",    done_n0, 2);

        // T3: start pulsed mid-shift is ignored
        clear0();
        send(0, 8'h81, 1'b0, e0);
        wait_cycles(5);
        pulse(0, 8'h00, 1'b1, tmp);
        check("t3_busy", ifc0.busy, 1);
        wait_done(0, 100, d);
        wait_cycles(40);
        check("t3_dones", done_n0, 1);
        check("t3_rises", rise0, 8);
        check("t3_byte",  cap0[7:0], 8'h81);
        check("t3_dcx",   ifc0.spi_dcx, 0);
        check("t3_cs_hi", ifc0.spi_cs_n, 1);

        // T4: reset at E0+10 aborts the byte
        clear0();
        send(0, 8'hF0, 1'b1, e0);
        while (cyc < e0 + 9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t4_cs_hi",   ifc0.spi_cs_n, 1);
        check("t4_sck_lo",  ifc0.spi_sck,  0);
        check("t4_busy_lo", ifc0.busy,     0);
        rst = 1'b1;
        wait_cycles(40);
        check("t4_no_done", done_n0, 0);
        clear0();
        send(0, 8'h3C, 1'b1, e0);
        wait_done(0, 100, d);
        check("t4_done_lat", d - e0, 32);
        check("t4_byte",     cap0[7:0], 8'h3C);
        check("t4_rises",    rise0, 8);

        // T5: start exactly on the linger timeout edge (E_done + 16)
        while (cyc < d + 15) @(negedge clk);
        pulse(0, 8'h5A, 1'b0, e0);
        check("t5_cs_lo", ifc0.spi_cs_n, 0);
        wait_done(0, 100, d2);
        check("t5_done_lat", d2 - e0, 32);
        check("t5_bytes",    cap0, 16'h3C5A);
        check("t5_no_cs_up", cs_rise0, 0);
        check("t5_dcx",      ifc0.spi_dcx, 0);
        wait_cycles(20);

        // T6: CLK_DIV=1 instance, byte 0x55
        clear1();
        send(1, 8'h55, 1'b1, e0);
        wait_done(1, 100, d);
        check("t6_done_lat", d - e0, 16);
        check("t6_byte",     cap1[7:0], 8'h55);
        check("t6_rises",    rise1, 8);
        wait_cycles(10);
        check("t6_toggles",  tog1, 16);
        check("t6_cs_time",  cs_cyc1 - e0, 20);
        check("t6_dones",    done_n1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_spi_tx.md
# lcd_spi_tx

Byte-serial SPI transmitter that drives the LCD panel on behalf of the memory-mapped control/render interface. It accepts one byte plus a data/command flag per `start` pulse, shifts it out MSB-first in SPI mode 0, and returns a one-cycle `done` pulse. Chip select stays asserted between closely spaced bytes, so framebuffer line dumps stream without CS toggling. The block sits directly downstream of the controller's `lcd_data_in` / `lcd_data_dcx` / `lcd_start` / `lcd_done` signals.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles; must be ≥1.
- `CS_IDLE`, default 16: `clk` cycles CS is held low after `done` while waiting for another byte; must be ≥1.

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `data_in` in 8: byte to send; sampled when `start` is accepted.
- `data_dcx` in 1: 0 = command, 1 = data; sampled with `data_in`.
- `start` in 1: single-cycle request.
- `done` out 1: one-cycle pulse when a byte completes.
- `busy` out 1: high while a byte is shifting.
- `spi_sck` out 1: serial clock; idles low.
- `spi_mosi` out 1: serial data.
- `spi_cs_n` out 1: chip select, active low.
- `spi_dcx` out 1: D/C line to the panel.

## Operation
- Three states:
  - IDLE: CS high.
  - SHIFT: a byte is in flight.
  - LINGER: CS still low, no byte in flight.
- `start` is accepted only in IDLE or LINGER. In SHIFT it is ignored: no latch, no queue.
- On accept:
  - latch `data_in` into a shift register and `data_dcx` into `spi_dcx`;
  - drive `spi_cs_n`=0 and `spi_mosi`=`data_in[7]`;
  - clear the bit counter and divider, then enter SHIFT.
- SHIFT, for each of 8 bits:
  - low phase of `CLK_DIV` cycles, then `spi_sck`=1 for `CLK_DIV` cycles (panel samples on the rising edge);
  - on the falling edge, shift left and present the next bit on `spi_mosi`.
- After bit 0's high phase, SCK returns low, `done` pulses and the state moves to LINGER. `spi_mosi` holds its last value.
- LINGER:
  - The counter runs from 0. On reaching `CS_IDLE`, drive `spi_cs_n`=1 and go to IDLE.
  - A `start` accepted on the same cycle as the timeout wins: CS stays low and the state goes to SHIFT.
- `spi_dcx` changes only on accept. It is held through LINGER and IDLE.
- Counter widths: divider is $clog2(CLK_DIV)+1 bits; linger counter is $clog2(CS_IDLE)+1 bits; bit counter is 3 bits. No wrap is ever observable.

## Timing
- Reset values (`rst`=0 at an edge): `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `spi_dcx`=0, `done`=0, `busy`=0, all counters 0, state IDLE.
- Reset mid-byte aborts immediately; no `done` is issued.
- Let E0 be the edge at which `start` is accepted:
  - outputs change at E0;
  - `busy`=1 from E0 until the edge that raises `done`;
  - rising edge of bit k (k=0 is the MSB) is at E0 + `CLK_DIV`·(2k+1);
  - falling edge is at E0 + `CLK_DIV`·(2k+2).
- `done` is high for the single cycle following edge E0 + 16·`CLK_DIV`, which is the same edge at which SCK falls for the last time.
- Byte period: 16·`CLK_DIV` cycles.
  - The earliest next accept is one cycle after `done`, because the controller reacts to `done`.
  - For back-to-back bytes, the first SCK low phase of the new byte equals `CLK_DIV` cycles; there is no extra setup.
- CS deasserts at edge E_done + `CS_IDLE` when no `start` arrives. It is never deasserted inside SHIFT.
- `spi_mosi` is stable for `CLK_DIV` cycles before and after every rising SCK edge.

## Test plan
- Single byte, `CLK_DIV`=2, `CS_IDLE`=16, `data_in`=0xA5, `dcx`=1 → bits captured on rising SCK are 1,0,1,0,0,1,0,1; exactly 8 rising edges; `done` follows edge E0+32; `spi_cs_n` rises at E0+48; `spi_dcx`=1 throughout.
- Back-to-back: send 0x2C with `dcx`=0, then 0xFF with `dcx`=1, issuing `start` one cycle after the first `done` → CS stays low across both bytes; `spi_dcx` goes 0→1 at the second accept; 16 rising edges total; two `done` pulses 33 cycles apart.
- `start` pulsed mid-SHIFT with `data_in`=0x00 while 0x81 is shifting → the captured byte is 0x81; exactly one `done`; no second transfer.
- Reset asserted at E0+10 of a byte → from the next edge: `spi_cs_n`=1, `spi_sck`=0, `busy`=0, and no `done` pulse. A subsequent 0x3C transfers correctly.
- `start` on the exact LINGER timeout edge (E_done+`CS_IDLE`) → `spi_cs_n` never rises; the new byte shifts normally.
- `CLK_DIV`=1, byte 0x55 → SCK toggles every cycle; `done` follows E0+16; captured bits are 0,1,0,1,0,1,0,1.
